msrv32_fetch_queue: RTL and testbench

Instruction fetch front end for the msrv32 core. It issues sequential word fetches to instruction memory over a request/grant + in-order response interface and buffers returned words in a DEPTH-entry FIFO with their PCs. It presents one instruction per cycle to decode and immediate generation through a valid/ready handshake. On flush it redirects to a new PC and discards stale in-flight responses.

---
 rtl/msrv32_fetch_queue_if.sv | 37 +++
 rtl/msrv32_fetch_queue.sv | 135 +++++++++++++
 tb/tb_msrv32_fetch_queue.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/grant/response plus the
// valid/ready instruction stream toward decode and immediate generation.
interface msrv32_fetch_queue_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_ready_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_gnt_in,
    input  imem_rvalid_in,
    input  imem_rdata_in,
    output instr_valid_out,
    output instr_out,
    output pc_out,
    input  instr_ready_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_gnt_in,
    output imem_rvalid_in,
    output imem_rdata_in,
    input  instr_valid_out,
    input  instr_out,
    input  pc_out,
    output instr_ready_in
  );
endinterface

// File: rtl/msrv32_fetch_queue.sv
// msrv32 fetch front end: credit-limited sequential word fetch, in-order response
// FIFO of {pc, instr}, and flush redirect that discards stale in-flight responses.
module msrv32_fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic [31:0]                 flush_pc_in,
  msrv32_fetch_queue_if.master        bus
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] rpc_q, rpc_d;
  cnt_t        occ_q, occ_d;
  cnt_t        outs_q, outs_d;
  cnt_t        disc_q, disc_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;

  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];

  logic [CW:0] credit_used;
  logic        req;
  logic        fire;
  logic        rsp;
  logic        drop_rsp;
  logic        push;
  logic        pop;
  logic        valid;
  logic [31:0] flush_target;
  logic        unused_flush_lsb;

  assign flush_target     = {flush_pc_in[31:2], 2'b00};
  assign unused_flush_lsb = ^flush_pc_in[1:0];

  // Every request in flight owns a FIFO slot, so a response can always be pushed.
  assign credit_used = {1'b0, occ_q} + {1'b0, outs_q};
  assign req         = !rst_in && !flush_in && (credit_used < (CW+1)'(DEPTH));
  assign fire        = req && bus.imem_gnt_in;

  // A response with nothing outstanding is illegal and ignored.
  assign rsp      = bus.imem_rvalid_in && (outs_q != '0);
  assign drop_rsp = rsp && (disc_q != '0);
  assign push     = rsp && !drop_rsp && !flush_in && !rst_in;

  assign valid = !rst_in && !flush_in && (occ_q != '0);
  assign pop   = valid && bus.instr_ready_in;

  assign bus.imem_req_out    = req;
  assign bus.imem_addr_out   = fpc_q;
  assign bus.instr_valid_out = valid;
  assign bus.instr_out       = (!rst_in && occ_q != '0) ? fifo_instr_q[rd_ptr_q] : NOP;
  assign bus.pc_out          = (!rst_in && occ_q != '0) ? fifo_pc_q[rd_ptr_q]    : 32'h0;

  always_comb begin
    fpc_d    = fpc_q;
    rpc_d    = rpc_q;
    occ_d    = occ_q;
    disc_d   = disc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    outs_d   = outs_q + cnt_t'(fire) - cnt_t'(rsp);

    if (flush_in) begin
      fpc_d    = flush_target;
      rpc_d    = flush_target;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // Everything still outstanding after this cycle belongs to the old stream.
      disc_d   = outs_q - cnt_t'(rsp);
    end else begin
      if (fire) begin
        fpc_d = fpc_q + 32'd4;
      end
      if (push) begin
        rpc_d    = rpc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      if (drop_rsp) begin
        disc_d = disc_q - cnt_t'(1);
      end
      occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fpc_q    <= RESET_PC;
      rpc_q    <= RESET_PC;
      occ_q    <= '0;
      outs_q   <= '0;
      disc_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      occ_q    <= occ_d;
      outs_q   <= outs_d;
      disc_q   <= disc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= rpc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata_in;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_in) begin
    if (push && !pop) begin
      assert (occ_q < cnt_t'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_msrv32_fetch_queue.sv
// Randomized scoreboard bench for msrv32_fetch_queue: a transaction-level model of
// outstanding fetches and the delivered instruction stream predicts every output.
module tb_msrv32_fetch_queue;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;

  msrv32_fetch_queue_if bus ();

  msrv32_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .flush_in    (flush),
    .flush_pc_in (flush_pc),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: fetch PC, response PC, one tag per outstanding request
  // (1 = belongs to a flushed stream), and the delivered-but-unconsumed entries.
  logic [31:0] m_fpc;
  logic [31:0] m_rpc;
  bit          tags[$];
  logic [63:0] sb[$];

  // Memory environment: in-order responses with random latency.
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t pend[$];
  int   cyc = 0;

  // Stimulus knobs (percent probabilities).
  int p_gnt = 100, p_rdy = 100, p_flush = 0, p_rv = 100, max_lat = 0;
  bit force_flush = 0;
  logic [31:0] force_pc = 32'h0;

  // Values sampled at negedge, consumed at the following posedge.
  logic        s_rst, s_flush, s_gnt, s_rvalid, s_ready, s_dut_req, s_er, s_ev;
  logic [31:0] s_flush_pc, s_rdata;

  always @(negedge clk) begin
    s_rst      = rst;
    s_flush    = flush;
    s_flush_pc = flush_pc;
    s_gnt      = bus.imem_gnt_in;
    s_rvalid   = bus.imem_rvalid_in;
    s_rdata    = bus.imem_rdata_in;
    s_ready    = bus.instr_ready_in;
    s_dut_req  = bus.imem_req_out;
    if (rst) begin
      s_er = 1'b0;
      s_ev = 1'b0;
      chk("rst_req",   bus.imem_req_out,    32'd0);
      chk("rst_valid", bus.instr_valid_out, 32'd0);
      chk("rst_instr", bus.instr_out,       NOP);
      chk("rst_pc",    bus.pc_out,          32'd0);
    end else begin
      s_er = !flush && ((sb.size() + tags.size()) < DEPTH);
      s_ev = !flush && (sb.size() != 0);
      chk("req", bus.imem_req_out, s_er);
      if (s_er) chk("addr", bus.imem_addr_out, m_fpc);
      chk("valid", bus.instr_valid_out, s_ev);
      if (sb.size() != 0) begin
        if (s_ev) begin
          chk("pc",    bus.pc_out,    sb[0][63:32]);
          chk("instr", bus.instr_out, sb[0][31:0]);
        end
      end else begin
        chk("idle_instr", bus.instr_out, NOP);
        chk("idle_pc",    bus.pc_out,    32'd0);
      end
    end
  end

  always @(posedge clk) begin
    bit stale;
    cyc++;
    if (s_rst) begin
      m_fpc = RESET_PC;
      m_rpc = RESET_PC;
      tags.delete();
      sb.delete();
      pend.delete();
    end else begin
      if (s_ev && s_ready) void'(sb.pop_front());
      if (s_rvalid && tags.size() != 0) begin
        stale = tags.pop_front();
        if (!stale && !s_flush) begin
          sb.push_back({m_rpc, s_rdata});
          m_rpc = m_rpc + 32'd4;
        end
      end
      if (s_flush) begin
        sb.delete();
        foreach (tags[i]) tags[i] = 1'b1;
        m_fpc = {s_flush_pc[31:2], 2'b00};
        m_rpc = {s_flush_pc[31:2], 2'b00};
      end else if (s_er && s_gnt) begin
        tags.push_back(1'b0);
        m_fpc = m_fpc + 32'd4;
      end
      if (s_rvalid && pend.size() != 0) void'(pend.pop_front());
      if (s_dut_req && s_gnt) begin
        rsp_t r;
        r.data = $urandom;
        r.due  = cyc + int'($urandom_range(0, max_lat));
        pend.push_back(r);
      end
    end
  end

  task automatic drive();
    bus.imem_gnt_in    = ($urandom_range(0, 99) < p_gnt);
    bus.instr_ready_in = ($urandom_range(0, 99) < p_rdy);
    if (force_flush) begin
      flush       = 1'b1;
      flush_pc    = force_pc;
      force_flush = 0;
    end else begin
      flush = !rst && ($urandom_range(0, 99) < p_flush);
      if ($urandom_range(0, 3) == 0) flush_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           flush_pc = $urandom;
    end
    if (!rst && pend.size() != 0 && pend[0].due <= cyc && ($urandom_range(0, 99) < p_rv)) begin
      bus.imem_rvalid_in = 1'b1;
      bus.imem_rdata_in  = pend[0].data;
    end else begin
      bus.imem_rvalid_in = 1'b0;
      bus.imem_rdata_in  = $urandom;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic knobs(input int g, input int r, input int f, input int v, input int l);
    p_gnt = g; p_rdy = r; p_flush = f; p_rv = v; max_lat = l;
  endtask

  initial begin
    rst                = 1'b1;
    flush              = 1'b0;
    flush_pc           = 32'h0;
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;
    bus.instr_ready_in = 1'b0;
    run(3);
    @(posedge clk); #1; rst = 1'b0; drive();

    knobs(100, 100, 0, 100, 0);   // streaming, one-cycle response
    run(40);
    knobs(100, 0, 0, 100, 0);     // backpressure fills FIFO, credit stops requests
    run(10);
    knobs(100, 100, 0, 100, 0);
    run(10);

    knobs(100, 100, 0, 100, 3);   // redirect while responses in flight
    run(4);
    force_pc = 32'h0000_0102; force_flush = 1;
    run(20);
    knobs(100, 0, 0, 100, 0);     // full FIFO, then pop and push together
    run(8);
    knobs(100, 100, 0, 100, 0);
    run(8);

    force_pc = 32'hFFFF_FFF6; force_flush = 1;  // address wrap
    run(12);

    knobs(70, 60, 6, 70, 3);
    run(1500);
    knobs(100, 100, 30, 100, 1);  // back-to-back flushes likely
    run(300);

    knobs(100, 0, 0, 100, 2);     // reset mid-stream
    run(6);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    knobs(80, 70, 4, 80, 2);
    run(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
